load_store_unit: RTL and testbench

- Multi-cycle load/store engine for the RV32I core, driven from the core's memory state.
- Computes the effective address and checks alignment.
- Runs one request/acknowledge transaction on the data-memory bus.
- Returns sign- or zero-extended load data, and flags misaligned accesses and bus timeouts.

---
 rtl/load_store_unit_pkg.sv | 21 ++
 rtl/load_store_unit_align.sv | 74 +++++++
 rtl/load_store_unit.sv | 219 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 widths, fault causes, FSM states.
package load_store_unit_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_FAULT = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane logic: store packing, load extraction with extension, legality and alignment checks.
module load_store_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic        force_align,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [1:0]  eff_lane,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_value,
  output logic        illegal,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    if (is_store) begin
      illegal = !(funct3 inside {LS_B, LS_H, LS_W});
    end else begin
      illegal = !(funct3 inside {LS_B, LS_H, LS_W, LS_BU, LS_HU});
    end

    // Force-aligned stores drop the low address bits before the alignment check.
    eff_lane = lane;
    if (is_store && force_align) begin
      if (funct3 == LS_H) begin
        eff_lane[0] = 1'b0;
      end else if (funct3 == LS_W) begin
        eff_lane = 2'b00;
      end
    end

    misaligned = 1'b0;
    case (funct3)
      LS_H, LS_HU: misaligned = eff_lane[0];
      LS_W:        misaligned = (eff_lane != 2'b00);
      default:     misaligned = 1'b0;
    endcase

    wstrb = 4'b0000;
    wdata = store_data;
    if (is_store) begin
      case (funct3)
        LS_B: begin
          wstrb = 4'b0001 << eff_lane;
          wdata = {4{store_data[7:0]}};
        end
        LS_H: begin
          wstrb = 4'b0011 << eff_lane;
          wdata = {2{store_data[15:0]}};
        end
        LS_W:    wstrb = 4'b1111;
        default: wstrb = 4'b0000;
      endcase
    end

    rbyte = rdata[{lane, 3'b000} +: 8];
    rhalf = rdata[{lane[1], 4'b0000} +: 16];
    case (funct3)
      LS_B:    load_value = {{24{rbyte[7]}}, rbyte};
      LS_BU:   load_value = {24'd0, rbyte};
      LS_H:    load_value = {{16{rhalf[15]}}, rhalf};
      LS_HU:   load_value = {16'd0, rhalf};
      default: load_value = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store engine: one req/ack bus transaction per start, with
// alignment faults and a bounded wait for mem_ready.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH                   = 32,
  parameter int TIMEOUT_CYCLES               = 16,
  parameter int ALLOW_MISALIGNED_STORE_FAULT = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           base,
  input  logic [31:0]           offset,
  input  logic [31:0]           store_data,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  fault,
  output logic [1:0]            fault_cause,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam bit TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam bit FORCE_ALIGN = (ALLOW_MISALIGNED_STORE_FAULT == 0);
  localparam int WAIT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e            state_q, state_d;
  logic [1:0]            lane_q, lane_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            cause_q, cause_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [31:0]           load_data_q, load_data_d;
  logic                  fault_q, fault_d;
  logic [1:0]            fault_cause_q, fault_cause_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;

  logic [31:0]           ea_sum;
  logic [ADDR_WIDTH-1:0] ea_new;
  logic                  in_idle;
  logic [1:0]            al_lane;
  logic [2:0]            al_funct3;
  logic                  al_is_store;
  logic [1:0]            al_eff_lane;
  logic [3:0]            al_wstrb;
  logic [31:0]           al_wdata;
  logic [31:0]           al_load_value;
  logic                  al_illegal;
  logic                  al_misaligned;

  assign ea_sum  = base + offset;
  assign ea_new  = ea_sum[ADDR_WIDTH-1:0];
  assign in_idle = (state_q == ST_IDLE);

  // The aligner sees live request fields in IDLE and the latched ones afterwards,
  // so a single instance serves both store packing and load extraction.
  assign al_lane     = in_idle ? ea_new[1:0] : lane_q;
  assign al_funct3   = in_idle ? funct3      : funct3_q;
  assign al_is_store = in_idle ? is_store    : is_store_q;

  load_store_align u_align (
    .lane        (al_lane),
    .funct3      (al_funct3),
    .is_store    (al_is_store),
    .force_align (FORCE_ALIGN),
    .store_data  (store_data),
    .rdata       (rdata_q),
    .eff_lane    (al_eff_lane),
    .wstrb       (al_wstrb),
    .wdata       (al_wdata),
    .load_value  (al_load_value),
    .illegal     (al_illegal),
    .misaligned  (al_misaligned)
  );

  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    is_store_d    = is_store_q;
    funct3_d      = funct3_q;
    rdata_d       = rdata_q;
    cause_d       = cause_q;
    wait_d        = wait_q;
    load_data_d   = load_data_q;
    done_d        = 1'b0;
    fault_d       = 1'b0;
    fault_cause_d = FAULT_NONE;
    mem_valid_d   = mem_valid_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wstrb_d   = mem_wstrb_q;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          lane_d     = al_eff_lane;
          wait_d     = '0;
          if (al_illegal || al_misaligned) begin
            cause_d = FAULT_MISALIGN;
            state_d = ST_FAULT;
          end else begin
            mem_valid_d = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {ea_new[ADDR_WIDTH-1:2], 2'b00};
            mem_wstrb_d = al_wstrb;
            mem_wdata_d = al_wdata;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          rdata_d     = mem_rdata;
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          state_d     = ST_RESP;
        end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          cause_d     = FAULT_TIMEOUT;
          wait_d      = '0;
          state_d     = ST_FAULT;
        end else if (wait_q != {WAIT_W{1'b1}}) begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RESP: begin
        done_d = 1'b1;
        if (!is_store_q) begin
          load_data_d = al_load_value;
        end
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        done_d        = 1'b1;
        fault_d       = 1'b1;
        fault_cause_d = cause_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      lane_q        <= '0;
      is_store_q    <= 1'b0;
      funct3_q      <= '0;
      rdata_q       <= '0;
      cause_q       <= FAULT_NONE;
      wait_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      load_data_q   <= '0;
      fault_q       <= 1'b0;
      fault_cause_q <= FAULT_NONE;
      mem_valid_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wstrb_q   <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      is_store_q    <= is_store_d;
      funct3_q      <= funct3_d;
      rdata_q       <= rdata_d;
      cause_q       <= cause_d;
      wait_q        <= wait_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      load_data_q   <= load_data_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      mem_valid_q   <= mem_valid_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wstrb_q   <= mem_wstrb_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign load_data   = load_data_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;
  assign mem_valid   = mem_valid_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: dut1 uses default parameters, dut2 has a 4-cycle timeout
// and force-aligns misaligned stores.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start2, rdy1, rdy2;
  logic        s_is_store;
  logic [2:0]  s_funct3;
  logic [31:0] s_base, s_offset, s_store_data, s_rdata;

  logic        busy1, done1, fault1, valid1, we1;
  logic [1:0]  cause1;
  logic [31:0] ld1, addr1, wd1;
  logic [3:0]  strb1;
  logic        busy2, done2, fault2, valid2, we2;
  logic [1:0]  cause2;
  logic [31:0] ld2, addr2, wd2;
  logic [3:0]  strb2;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_ld1 = 32'd0;
  logic [31:0] exp_ld2 = 32'd0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          dc;
    int          vc;
    bit          stable;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic        we;
    logic        flt;
    logic [1:0]  cause;
    logic [31:0] ld;
  } obs_t;

  // Clock and reset
  always #5 clk = ~clk;

  load_store_unit dut1 (
    .CLK(clk), .RESET(reset), .start(start1), .is_store(s_is_store), .funct3(s_funct3),
    .base(s_base), .offset(s_offset), .store_data(s_store_data),
    .busy(busy1), .done(done1), .load_data(ld1), .fault(fault1), .fault_cause(cause1),
    .mem_valid(valid1), .mem_ready(rdy1), .mem_we(we1), .mem_addr(addr1),
    .mem_wstrb(strb1), .mem_wdata(wd1), .mem_rdata(s_rdata)
  );

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4), .ALLOW_MISALIGNED_STORE_FAULT(0)) dut2 (
    .CLK(clk), .RESET(reset), .start(start2), .is_store(s_is_store), .funct3(s_funct3),
    .base(s_base), .offset(s_offset), .store_data(s_store_data),
    .busy(busy2), .done(done2), .load_data(ld2), .fault(fault2), .fault_cause(cause2),
    .mem_valid(valid2), .mem_ready(rdy2), .mem_we(we2), .mem_addr(addr2),
    .mem_wstrb(strb2), .mem_wdata(wd2), .mem_rdata(s_rdata)
  );

  // Reference model: RV32I access rules expressed with byte arithmetic.
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] ea_in,
                                input logic [31:0] sd, input logic [31:0] rd, input bit force_al,
                                output bit flt, output logic [31:0] addr, output logic [3:0] strb,
                                output logic [31:0] wd, output logic [31:0] ld);
    int unsigned ea, size, lane;
    longint unsigned mask, val;
    ea = ea_in;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    flt = (size == 0) || (st && f3 > 3'd2);
    if (!flt) begin
      if (st && force_al) ea = ea - (ea % size);
      if ((ea % size) != 0) flt = 1;
    end
    addr = ea & 32'hFFFF_FFFC;
    lane = ea % 4;
    strb = 4'b0000;
    wd   = sd;
    ld   = 32'd0;
    if (st && !flt) begin
      strb = 4'(((1 << size) - 1) << lane);
      if (size == 1) wd = {24'd0, sd[7:0]} * 32'h0101_0101;
      else if (size == 2) wd = {16'd0, sd[15:0]} * 32'h0001_0001;
    end
    if (size != 0) begin
      mask = (64'd1 << (8 * size)) - 1;
      val  = (64'(rd) >> (8 * lane)) & mask;
      if (f3 < 3'd4 && val[8*size-1]) val = val | ~mask;
      ld = val[31:0];
    end
  endfunction

  // Driver/monitor: issue one request and observe the bus until done.
  task automatic do_txn(input bit d2, input logic st, input logic [2:0] f3, input logic [31:0] b,
                        input logic [31:0] o, input logic [31:0] sd, input logic [31:0] rd,
                        input int delay, output obs_t ob);
    logic v, rdy;
    ob = '{dc: -1, vc: 0, stable: 1'b1, addr: '0, strb: '0, wd: '0, we: 1'b0,
           flt: 1'b0, cause: '0, ld: '0};
    @(negedge clk);
    s_is_store = st; s_funct3 = f3; s_base = b; s_offset = o; s_store_data = sd;
    if (d2) start2 = 1'b1; else start1 = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      if (d2 ? done2 : done1) begin
        ob.dc    = cyc;
        ob.flt   = d2 ? fault2 : fault1;
        ob.cause = d2 ? cause2 : cause1;
        ob.ld    = d2 ? ld2 : ld1;
        break;
      end
      v = d2 ? valid2 : valid1;
      if (v) begin
        ob.vc++;
        if (ob.vc == 1) begin
          ob.addr = d2 ? addr2 : addr1;
          ob.strb = d2 ? strb2 : strb1;
          ob.wd   = d2 ? wd2 : wd1;
          ob.we   = d2 ? we2 : we1;
        end else if (ob.addr !== (d2 ? addr2 : addr1) || ob.strb !== (d2 ? strb2 : strb1) ||
                     ob.wd !== (d2 ? wd2 : wd1) || ob.we !== (d2 ? we2 : we1)) begin
          ob.stable = 1'b0;
        end
      end
      rdy     = v ? (ob.vc == delay + 1) : 1'($urandom_range(0, 1));
      s_rdata = (v && ob.vc == delay + 1) ? rd : $urandom;
      if (d2) rdy2 = rdy; else rdy1 = rdy;
    end
    rdy1 = 1'b0; rdy2 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy1, done1, fault1, cause1, valid1, we1, strb1} !== 11'd0) begin failures++; $display("FAIL reset_ctrl1 got=%b exp=0", {busy1, done1, fault1, cause1, valid1, we1, strb1}); end
    checks++; if ({ld1, addr1, wd1} !== 96'd0) begin failures++; $display("FAIL reset_data1 got=%h exp=0", {ld1, addr1, wd1}); end
    checks++; if ({busy2, done2, fault2, cause2, valid2, we2, strb2, ld2, addr2, wd2} !== 107'd0) begin failures++; $display("FAIL reset_dut2 got=%h exp=0", {busy2, done2, fault2, cause2, valid2, we2, strb2, ld2, addr2, wd2}); end
    reset = 1'b0;
  endtask

  task automatic test_lbu;
    obs_t ob;
    do_txn(0, 1'b0, 3'b100, 32'h100, 32'd3, 32'h0, 32'h80AA55CC, 0, ob);
    exp_ld1 = 32'h0000_0080;
    checks++; if (ob.addr !== 32'h100) begin failures++; $display("FAIL lbu_addr got=%h exp=%h", ob.addr, 32'h100); end
    checks++; if (ob.strb !== 4'b0000 || ob.we !== 1'b0) begin failures++; $display("FAIL lbu_strb got=%b/%b exp=0000/0", ob.strb, ob.we); end
    checks++; if (ob.dc !== 3) begin failures++; $display("FAIL lbu_done_cycle got=%0d exp=3", ob.dc); end
    checks++; if (ob.ld !== exp_ld1 || ob.flt !== 1'b0) begin failures++; $display("FAIL lbu_data got=%h/%b exp=%h/0", ob.ld, ob.flt, exp_ld1); end
  endtask

  task automatic test_sh;
    obs_t ob;
    do_txn(0, 1'b1, 3'b001, 32'h200, 32'hFFFF_FFFE, 32'h1234ABCD, 32'h5555_5555, 0, ob);
    checks++; if (ob.addr !== 32'h1FC) begin failures++; $display("FAIL sh_addr got=%h exp=%h", ob.addr, 32'h1FC); end
    checks++; if (ob.strb !== 4'b1100 || ob.we !== 1'b1) begin failures++; $display("FAIL sh_strb got=%b/%b exp=1100/1", ob.strb, ob.we); end
    checks++; if (ob.wd !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=ABCDABCD", ob.wd); end
    checks++; if (ob.ld !== exp_ld1 || ob.dc !== 3 || ob.flt !== 1'b0) begin failures++; $display("FAIL sh_done got=%h/%0d/%b exp=%h/3/0", ob.ld, ob.dc, ob.flt, exp_ld1); end
  endtask

  task automatic test_misaligned;
    obs_t ob;
    do_txn(0, 1'b0, 3'b010, 32'h102, 32'd0, 32'h0, 32'h0, 0, ob);
    checks++; if (ob.vc !== 0 || ob.dc !== 2) begin failures++; $display("FAIL lw_mis_timing got=vc%0d/dc%0d exp=vc0/dc2", ob.vc, ob.dc); end
    checks++; if (ob.flt !== 1'b1 || ob.cause !== 2'b01 || ob.ld !== exp_ld1) begin failures++; $display("FAIL lw_mis_fault got=%b/%b/%h exp=1/01/%h", ob.flt, ob.cause, ob.ld, exp_ld1); end
    do_txn(0, 1'b0, 3'b001, 32'h100, 32'd3, 32'h0, 32'h0, 0, ob);
    checks++; if (ob.vc !== 0 || ob.dc !== 2 || ob.flt !== 1'b1 || ob.cause !== 2'b01) begin failures++; $display("FAIL lh_mis got=vc%0d/dc%0d/%b/%b exp=vc0/dc2/1/01", ob.vc, ob.dc, ob.flt, ob.cause); end
  endtask

  task automatic test_wait_states;
    obs_t ob;
    do_txn(0, 1'b0, 3'b001, 32'h106, 32'd0, 32'h0, 32'h8001_7E3A, 5, ob);
    exp_ld1 = 32'hFFFF_8001;
    checks++; if (ob.vc !== 6 || ob.stable !== 1'b1 || ob.addr !== 32'h104) begin failures++; $display("FAIL lh_wait_bus got=vc%0d/st%b/%h exp=vc6/st1/104", ob.vc, ob.stable, ob.addr); end
    checks++; if (ob.dc !== 8) begin failures++; $display("FAIL lh_wait_done got=%0d exp=8", ob.dc); end
    checks++; if (ob.ld !== exp_ld1 || ob.flt !== 1'b0) begin failures++; $display("FAIL lh_wait_data got=%h/%b exp=%h/0", ob.ld, ob.flt, exp_ld1); end
  endtask

  task automatic test_random;
    obs_t ob;
    bit eflt, tmo;
    logic st;
    logic [2:0] f3;
    logic [11:0] imm;
    logic [31:0] b, o, sd, rd, eaddr, ewd, eld, got_exp;
    logic [3:0] estrb;
    int delay, evc, edc;
    logic [1:0] ecause;
    for (int n = 0; n < 60; n++) begin
      st    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      b     = $urandom;
      imm   = 12'($urandom);
      o     = {{20{imm[11]}}, imm};
      sd    = $urandom;
      rd    = $urandom;
      delay = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
      model(st, f3, b + o, sd, rd, 1'b0, eflt, eaddr, estrb, ewd, eld);
      do_txn(0, st, f3, b, o, sd, rd, delay, ob);
      tmo    = !eflt && (delay >= 16);
      ecause = eflt ? 2'b01 : (tmo ? 2'b10 : 2'b00);
      evc    = eflt ? 0 : (tmo ? 16 : delay + 1);
      edc    = eflt ? 2 : (tmo ? 18 : delay + 3);
      if (!eflt && !tmo && !st) exp_ld1 = eld;
      exp_q.push_back(exp_ld1);
      got_exp = exp_q.pop_front();
      checks++; if (ob.dc !== edc || ob.vc !== evc) begin failures++; $display("FAIL rnd%0d_timing got=dc%0d/vc%0d exp=dc%0d/vc%0d", n, ob.dc, ob.vc, edc, evc); end
      checks++; if (ob.flt !== (eflt || tmo) || ob.cause !== ecause) begin failures++; $display("FAIL rnd%0d_fault got=%b/%b exp=%b/%b", n, ob.flt, ob.cause, eflt || tmo, ecause); end
      checks++; if (ob.ld !== got_exp) begin failures++; $display("FAIL rnd%0d_load_data got=%h exp=%h", n, ob.ld, got_exp); end
      if (!eflt) begin
        checks++; if (ob.addr !== eaddr || ob.strb !== estrb || ob.we !== st || ob.stable !== 1'b1) begin failures++; $display("FAIL rnd%0d_bus got=%h/%b/%b/%b exp=%h/%b/%b/1", n, ob.addr, ob.strb, ob.we, ob.stable, eaddr, estrb, st); end
        if (st) begin
          checks++; if (ob.wd !== ewd) begin failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, ob.wd, ewd); end
        end
      end
    end
  endtask

  task automatic test_force_align;
    obs_t ob;
    do_txn(1, 1'b1, 3'b010, 32'h203, 32'd0, 32'hDEADBEEF, 32'h0, 0, ob);
    checks++; if (ob.addr !== 32'h200 || ob.strb !== 4'b1111 || ob.wd !== 32'hDEADBEEF || ob.we !== 1'b1) begin failures++; $display("FAIL fa_sw_bus got=%h/%b/%h/%b exp=200/1111/DEADBEEF/1", ob.addr, ob.strb, ob.wd, ob.we); end
    checks++; if (ob.flt !== 1'b0 || ob.dc !== 3 || ob.ld !== exp_ld2) begin failures++; $display("FAIL fa_sw_done got=%b/%0d/%h exp=0/3/%h", ob.flt, ob.dc, ob.ld, exp_ld2); end
    do_txn(1, 1'b1, 3'b001, 32'h203, 32'd0, 32'h0000_5A3C, 32'h0, 1, ob);
    checks++; if (ob.addr !== 32'h200 || ob.strb !== 4'b1100 || ob.wd !== 32'h5A3C5A3C || ob.dc !== 4) begin failures++; $display("FAIL fa_sh got=%h/%b/%h/%0d exp=200/1100/5A3C5A3C/4", ob.addr, ob.strb, ob.wd, ob.dc); end
    do_txn(1, 1'b0, 3'b010, 32'h203, 32'd0, 32'h0, 32'h0, 0, ob);
    checks++; if (ob.flt !== 1'b1 || ob.cause !== 2'b01 || ob.vc !== 0) begin failures++; $display("FAIL fa_lw_still_faults got=%b/%b/vc%0d exp=1/01/vc0", ob.flt, ob.cause, ob.vc); end
  endtask

  task automatic test_timeout;
    int vc = 0;
    int dc = -1;
    logic flt = 1'b0;
    logic [1:0] cause = 2'b00;
    logic busy_at2 = 1'b0;
    logic [31:0] ld_at_done = 32'd0;
    @(negedge clk);
    s_is_store = 1'b0; s_funct3 = 3'b010; s_base = 32'h300; s_offset = 32'd0;
    start2 = 1'b1; rdy2 = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      start2 = (cyc == 2);
      if (cyc == 2) begin
        s_base   = 32'h400;
        busy_at2 = busy2;
      end
      if (valid2) vc++;
      if (done2) begin
        dc = cyc; flt = fault2; cause = cause2; ld_at_done = ld2;
      end
    end
    checks++; if (vc !== 4) begin failures++; $display("FAIL to_valid_cycles got=%0d exp=4", vc); end
    checks++; if (dc !== 6 || flt !== 1'b1 || cause !== 2'b10) begin failures++; $display("FAIL to_done got=%0d/%b/%b exp=6/1/10", dc, flt, cause); end
    checks++; if (busy_at2 !== 1'b1 || ld_at_done !== exp_ld2) begin failures++; $display("FAIL to_busy_ld got=%b/%h exp=1/%h", busy_at2, ld_at_done, exp_ld2); end
  endtask

  task automatic test_reset_mid_req;
    obs_t ob;
    logic saw = 1'b0;
    logic [31:0] rd;
    @(negedge clk);
    s_is_store = 1'b0; s_funct3 = 3'b010; s_base = 32'h104; s_offset = 32'd0;
    start1 = 1'b1; rdy1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    checks++; if (valid1 !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_valid got=%b exp=1", valid1); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({valid1, busy1, done1} !== 3'b000 || ld1 !== 32'd0) begin failures++; $display("FAIL rst_mid_state got=%b/%h exp=000/0", {valid1, busy1, done1}, ld1); end
    reset   = 1'b0;
    exp_ld1 = 32'd0;
    exp_ld2 = 32'd0;
    repeat (5) begin
      @(negedge clk);
      if (done1 || valid1) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL rst_mid_quiet got=%b exp=0", saw); end
    rd = $urandom;
    do_txn(0, 1'b0, 3'b010, 32'h104, 32'd0, 32'h0, rd, 1, ob);
    exp_ld1 = rd;
    checks++; if (ob.dc !== 4 || ob.flt !== 1'b0 || ob.ld !== exp_ld1 || ob.addr !== 32'h104) begin failures++; $display("FAIL rst_mid_after got=%0d/%b/%h/%h exp=4/0/%h/104", ob.dc, ob.flt, ob.ld, ob.addr, exp_ld1); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    s_is_store = 1'b0; s_funct3 = 3'b000; s_base = '0; s_offset = '0;
    s_store_data = '0; s_rdata = '0;
    test_reset;
    test_lbu;
    test_sh;
    test_misaligned;
    test_wait_states;
    test_random;
    test_force_align;
    test_timeout;
    test_reset_mid_req;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
